// File: rtl/uart_pkg.sv
// Shared types for the UART command assembler.
//   asm_state_t : frame-assembly state (which byte slot the next capture fills)
//   FRAME_BYTES : bytes per command frame (opcode, data hi, data lo)
package uart_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} asm_state_t;
  localparam int FRAME_BYTES = 3;
endpackage

// File: rtl/uart_cmd_assembler_timeout_cnt.sv
// timeout_cnt: up-counter with synchronous clear and count enable.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : force count to zero (wins over en_i)
//   en_i      : advance count by one
//   tc_o      : count currently equals TERMINAL
module timeout_cnt #(
  parameter int WIDTH    = 17,
  parameter int TERMINAL = 99999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == WIDTH'(TERMINAL));
endmodule

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: packs the UART receiver byte stream into 3-byte
// command frames {opcode, data_hi, data_lo} and holds the last frame.
//   clk, rst     : clock, synchronous active-high reset
//   rx_rdy       : receiver has a byte on rx_data
//   rx_data      : received byte
//   clr_rx_rdy   : one-cycle release pulse back to the receiver
//   clr_cmd_rdy  : consumer acknowledge of the held command
//   cmd_rdy      : opcode/data hold an unacknowledged frame
//   opcode, data : held frame
//   frame_err    : one-cycle pulse, partial frame dropped on inter-byte timeout
//   overrun      : one-cycle pulse, new frame replaced an unacknowledged one
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  opcode,
  output logic [15:0] data,
  output logic        frame_err,
  output logic        overrun
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  asm_state_t  state_q, state_d;
  logic [7:0]  op_sh_q, op_sh_d, hi_sh_q, hi_sh_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        clr_rx_q, clr_rx_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic capture, tc, timeout, cnt_clr, cnt_en;

  // A byte is taken only when no release pulse is outstanding; the receiver
  // still shows rdy during the pulse cycle, so this blocks double capture.
  assign capture = rx_rdy & ~clr_rx_q;
  // Capture on the terminal count keeps the frame alive.
  assign timeout = (state_q != IDLE) & tc & ~capture;
  assign cnt_clr = (state_q == IDLE) | capture | timeout;
  assign cnt_en  = (state_q != IDLE);

  timeout_cnt #(
    .WIDTH    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  always_comb begin
    state_d   = state_q;
    op_sh_d   = op_sh_q;
    hi_sh_d   = hi_sh_q;
    opcode_d  = opcode_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
    clr_rx_d  = capture;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    unique case (state_q)
      IDLE: if (capture) begin
        op_sh_d = rx_data;
        state_d = WAIT_HI;
      end
      WAIT_HI: if (capture) begin
        hi_sh_d = rx_data;
        state_d = WAIT_LO;
      end
      WAIT_LO: if (capture) begin
        opcode_d  = op_sh_q;
        data_d    = {hi_sh_q, rx_data};
        // Completion wins over a same-edge acknowledge.
        cmd_rdy_d = 1'b1;
        ovr_d     = cmd_rdy_q & ~clr_cmd_rdy;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      op_sh_d = '0;
      hi_sh_d = '0;
      ferr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_sh_q   <= '0;
      hi_sh_q   <= '0;
      opcode_q  <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
      clr_rx_q  <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_sh_q   <= op_sh_d;
      hi_sh_q   <= hi_sh_d;
      opcode_q  <= opcode_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      clr_rx_q  <= clr_rx_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign clr_rx_rdy = clr_rx_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign opcode     = opcode_q;
  assign data       = data_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_cmd_assembler.sv
module tb_uart_cmd_assembler;
  localparam int T = 100;

  logic        clk = 0;
  logic        rst, rx_rdy, clr_cmd_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy, cmd_rdy, frame_err, overrun;
  logic [7:0]  opcode;
  logic [15:0] data;

  uart_cmd_assembler #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy),
    .opcode(opcode), .data(data), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0, rand_ack = 0;
  int n_clr = 0, n_ferr = 0, n_ovr = 0;
  logic cmd_at_cap, ovr_at_cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: partial frame as a byte queue, idle edges since the last
  // byte of the frame; a frame is emitted when three bytes are collected.
  logic [7:0]  part[$];
  int          idle;
  logic        m_clr, m_cmd, m_fe, m_ov;
  logic [7:0]  m_op;
  logic [15:0] m_data;

  always @(posedge clk) begin
    if (rst) begin
      part.delete(); idle = 0;
      m_clr = 0; m_cmd = 0; m_fe = 0; m_ov = 0; m_op = 0; m_data = 0;
    end else begin
      logic cap;
      cap  = rx_rdy && !m_clr;
      m_fe = 0; m_ov = 0;
      if (cap) begin
        part.push_back(rx_data);
        idle = 0;
        if (part.size() == 3) begin
          m_ov   = m_cmd && !clr_cmd_rdy;
          m_op   = part[0];
          m_data = {part[1], part[2]};
          m_cmd  = 1;
          part.delete();
        end else if (clr_cmd_rdy) m_cmd = 0;
      end else begin
        if (clr_cmd_rdy) m_cmd = 0;
        if (part.size() > 0) begin
          idle++;
          if (idle == T) begin
            part.delete(); idle = 0; m_fe = 1;
          end
        end
      end
      m_clr = cap;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("clr_rx_rdy", clr_rx_rdy, m_clr);
    chk("cmd_rdy", cmd_rdy, m_cmd);
    chk("opcode", opcode, m_op);
    chk("data", data, m_data);
    chk("frame_err", frame_err, m_fe);
    chk("overrun", overrun, m_ov);
    if (clr_rx_rdy) n_clr++;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ack) clr_cmd_rdy = ($urandom_range(0, 7) == 0);
  end

  // Receiver behaviour: present byte, hold rdy until clr is seen, drop it at
  // the following edge. Entry/exit at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit ack = 0);
    bit got = 0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_rdy = 1; rx_data = b;
    if (ack) begin
      clr_cmd_rdy = 1;
      @(posedge clk); #1;
      clr_cmd_rdy = 0;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (clr_rx_rdy) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL clr_rx_rdy_timeout: got no pulse expected pulse for byte %0h", b);
    end
    cmd_at_cap = cmd_rdy;
    ovr_at_cap = overrun;
    @(posedge clk); #1;
    rx_rdy = 0; rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1); send_byte(b, 0); send_byte(c, 2);
  endtask

  task automatic ack_cmd();
    clr_cmd_rdy = 1;
    @(posedge clk); #1;
    clr_cmd_rdy = 0;
  endtask

  initial begin
    int c0, f0, o0;
    rst = 1; rx_rdy = 0; rx_data = 0; clr_cmd_rdy = 0;
    @(posedge clk); #1; chk_en = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("reset_cmd_rdy", cmd_rdy, 0);
    chk("reset_data", {opcode, data}, 0);
    @(posedge clk); #1;

    // Basic frame
    c0 = n_clr;
    send_frame(8'hA5, 8'h12, 8'h34);
    chk("f1_cmd_at_cap", cmd_at_cap, 1);
    chk("f1_clr_pulses", n_clr - c0, 3);
    chk("f1_opcode", opcode, 8'hA5);
    chk("f1_data", data, 16'h1234);

    // Acknowledge
    ack_cmd();
    @(negedge clk);
    chk("ack_cmd_rdy", cmd_rdy, 0);
    chk("ack_hold", {opcode, data}, 24'hA51234);
    @(posedge clk); #1;

    // Timeout on a partial frame
    f0 = n_ferr;
    send_byte(8'h01, 1); send_byte(8'h02, 0);
    repeat (T) begin @(posedge clk); #1; end
    chk("tmo_ferr_count", n_ferr - f0, 1);
    chk("tmo_no_cmd", cmd_rdy, 0);
    send_frame(8'h03, 8'h04, 8'h05);
    chk("tmo_next_frame", {cmd_rdy, opcode, data}, {1'b1, 24'h030405});
    ack_cmd();

    // Overrun
    o0 = n_ovr;
    send_frame(8'h10, 8'h00, 8'h01);
    send_frame(8'h20, 8'hBE, 8'hEF);
    chk("ovr_at_cap", ovr_at_cap, 1);
    chk("ovr_count", n_ovr - o0, 1);
    chk("ovr_frame", {cmd_rdy, opcode, data}, {1'b1, 24'h20BEEF});

    // Ack on the completion edge with a command still held
    send_byte(8'h30, 1); send_byte(8'h55, 0); send_byte(8'hAA, 0, 1);
    chk("simack_cmd", cmd_at_cap, 1);
    chk("simack_ovr", ovr_at_cap, 0);
    chk("simack_data", {cmd_rdy, data}, {1'b1, 16'h55AA});

    // Reset mid-frame
    send_byte(8'h11, 1);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rst_outputs", {cmd_rdy, opcode, data, clr_rx_rdy, frame_err, overrun}, 0);
    @(posedge clk); #1;
    send_frame(8'h7F, 8'h00, 8'hFF);
    chk("rst_frame", {cmd_rdy, opcode, data}, {1'b1, 24'h7F00FF});

    // Randomized traffic, gaps straddling the timeout boundary
    rand_ack = 1;
    for (int i = 0; i < 90; i++) begin
      int g;
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 5, T + 5) : $urandom_range(0, 4);
      send_byte(8'($urandom), g);
    end
    rand_ack = 0;
    clr_cmd_rdy = 0;
    repeat (T + 5) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
Downstream consumer of the UART receiver. Collects the receiver's byte stream into 3-byte command frames: opcode, data high byte, data low byte. Presents each completed frame as a held command with a ready flag to the command-processing logic. An inter-byte timeout resynchronises on partial frames, and a one-cycle pulse returns each byte slot to the receiver.

Parameters:
TIMEOUT_CYCLES, 100000, max idle clk cycles between bytes of one frame before the partial frame is discarded (must be >= 2)
CNT_W, $clog2(TIMEOUT_CYCLES), timeout counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  reset, synchronous, active-high
rx_rdy  input  1  receiver holds a valid byte on rx_data
rx_data  input  8  received byte
clr_rx_rdy  output  1  one-cycle pulse; releases the receiver's rdy
clr_cmd_rdy  input  1  consumer acknowledges the held command
cmd_rdy  output  1  opcode/data hold a complete, unacknowledged frame
opcode  output  8  frame byte 0
data  output  16  {frame byte 1, frame byte 2}
frame_err  output  1  one-cycle pulse: partial frame dropped on timeout
overrun  output  1  one-cycle pulse: new frame overwrote an unacknowledged one

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; cmd_rdy, clr_rx_rdy, frame_err, overrun = 0; opcode, data, shadow regs = 0; timeout counter = 0.
- Byte capture: occurs at a posedge where rx_rdy=1 and clr_rx_rdy=0. rx_data is registered into the byte slot selected by the state. clr_rx_rdy=1 for exactly the next cycle.
- rx_rdy is ignored while clr_rx_rdy=1. The receiver drops rdy at the edge after it sees clr, so no byte is double-captured.
- States:
  - IDLE: capture -> op_sh <= rx_data, go WAIT_HI.
  - WAIT_HI: capture -> hi_sh <= rx_data, go WAIT_LO.
  - WAIT_LO: capture -> opcode <= op_sh, data <= {hi_sh, rx_data}, cmd_rdy <= 1, go IDLE.
- Latency: cmd_rdy rises at the same posedge that captures byte 2. clr_rx_rdy for byte 2 is high in the following cycle.
- opcode/data change only at frame completion. They are stable while cmd_rdy=1 unless overrun occurs.
- cmd_rdy clears at a posedge with clr_cmd_rdy=1.
- Simultaneous clr_cmd_rdy and frame completion: completion wins. cmd_rdy stays 1, new values are loaded, no overrun.
- Completion while cmd_rdy=1 and clr_cmd_rdy=0: outputs are overwritten, cmd_rdy stays 1, overrun=1 for one cycle.
- Bytes are always consumed regardless of cmd_rdy. The receiver is never stalled.
- Timeout counter:
  - Cleared in IDLE and on every capture.
  - Otherwise increments each cycle in WAIT_HI/WAIT_LO.
  - When it equals TIMEOUT_CYCLES-1 with no capture that cycle: go IDLE, counter=0, frame_err=1 for one cycle, shadow bytes discarded, outputs untouched.
- Simultaneous capture and timeout-terminal count: capture wins, no frame_err.
- Reset mid-frame discards the partial frame and any held command.
- frame_err and overrun are never both 1 in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} asm_state_t
  - localparam FRAME_BYTES = 3
- One natural sub-module: timeout_cnt (parameterised up-counter with clear, enable and terminal-count output), instantiated once.
- FSM, capture registers and output flags stay in uart_cmd_assembler.

Test Plan:
- Bytes 0xA5, 0x12, 0x34, each rx_rdy held until clr_rx_rdy -> exactly 3 clr_rx_rdy pulses; cmd_rdy=1 at byte-3 capture edge; opcode=0xA5, data=0x1234.
- Hold command, pulse clr_cmd_rdy -> cmd_rdy=0 next cycle; opcode/data unchanged.
- TIMEOUT_CYCLES=100; send 0x01, 0x02, wait 100 cycles, then send 0x03, 0x04, 0x05 -> frame_err pulse once, no cmd_rdy from the partial frame; then opcode=0x03, data=0x0405.
- Frame 0x10,0x00,0x01 unacknowledged, then frame 0x20,0xBE,0xEF -> overrun pulse at second completion; opcode=0x20, data=0xBEEF, cmd_rdy=1.
- clr_cmd_rdy asserted on the same edge as completion of frame 0x30,0x55,0xAA -> cmd_rdy remains 1, data=0x55AA, overrun=0.
- rst=1 for one cycle after byte 1 of a frame, then full frame 0x7F,0x00,0xFF -> all outputs 0 after reset; cmd_rdy with opcode=0x7F, data=0x00FF.
